// File: rtl/pc_gen_if.sv
// Fetch-PC generator bus: redirect requests from D/CP0 in, fetch PC and EPC out.
// The core drives through "master"; pc_gen receives through "slave".
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic [WIDTH-1:0] d_pc;
    logic             j_en;
    logic [25:0]      j_instr26;
    logic             br_taken;
    logic [15:0]      br_imm;
    logic             jr_en;
    logic [WIDTH-1:0] jr_target;
    logic             exc;
    logic [WIDTH-1:0] exc_epc;
    logic             eret;
    logic             epc_we;
    logic [WIDTH-1:0] epc_wdata;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc_plus8;
    logic             f_adel;
    logic [WIDTH-1:0] epc;

    modport master (
        output stall, d_pc, j_en, j_instr26, br_taken, br_imm, jr_en, jr_target,
               exc, exc_epc, eret, epc_we, epc_wdata,
        input  pc, next_pc, pc_plus8, f_adel, epc
    );

    modport slave (
        input  stall, d_pc, j_en, j_instr26, br_taken, br_imm, jr_en, jr_target,
               exc, exc_epc, eret, epc_we, epc_wdata,
        output pc, next_pc, pc_plus8, f_adel, epc
    );
endinterface

// File: rtl/pc_gen.sv
// F-stage program-counter generator: fixed-priority next-PC select, EPC register
// and fetch-address fault flag for the pipelined MIPS core.
module pc_gen #(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_PC     = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BYTES = 32'h0000_4000
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);

    localparam logic [WIDTH-1:0] RESET_PC_W = RESET_PC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] EXC_PC_W   = EXC_PC[WIDTH-1:0];
    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);
    localparam logic [WIDTH-1:0] EIGHT      = WIDTH'(8);
    // Window bounds kept at 33 bits so a window ending at 2^32 cannot wrap.
    localparam logic [32:0]      FETCH_BASE  = {1'b0, IMEM_BASE};
    localparam logic [32:0]      FETCH_LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_STALL,
        SRC_JUMP,
        SRC_BRANCH,
        SRC_JR,
        SRC_SEQ
    } next_src_e;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;

    next_src_e        w_src;
    logic [WIDTH-1:0] w_next_pc;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_jump_pc;
    logic [WIDTH-1:0] w_br_offset;
    logic [WIDTH-1:0] w_br_pc;
    logic [WIDTH-1:0] w_eff_epc;
    logic [32:0]      w_pc_ext;
    logic             w_misaligned;
    logic             w_out_of_window;

    // ---------------- candidate targets ----------------
    assign w_seq_pc = r_pc + FOUR;

    // The region bits above the 256 MB segment come from the jump's own PC.
    if (WIDTH > 28) begin : g_jump_region
        assign w_jump_pc = {bus.d_pc[WIDTH-1:28], bus.j_instr26, 2'b00};
    end else begin : g_jump_flat
        assign w_jump_pc = {bus.j_instr26, 2'b00};
    end

    assign w_br_offset = {{(WIDTH-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};
    assign w_br_pc     = bus.d_pc + FOUR + w_br_offset;

    // An mtc0 to EPC in the same cycle as eret must be seen by that eret.
    assign w_eff_epc = bus.epc_we ? bus.epc_wdata : r_epc;

    // ---------------- priority select ----------------
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_src = SRC_SEQ;
        if (bus.exc) begin
            w_src = SRC_EXC;
        end else if (bus.eret) begin
            w_src = SRC_ERET;
        end else if (bus.stall) begin
            w_src = SRC_STALL;
        end else if (bus.j_en) begin
            w_src = SRC_JUMP;
        end else if (bus.br_taken) begin
            w_src = SRC_BRANCH;
        end else if (bus.jr_en) begin
            w_src = SRC_JR;
        end
    end

    always_comb begin
        w_next_pc = w_seq_pc;
        unique case (w_src)
            SRC_EXC:    w_next_pc = EXC_PC_W;
            SRC_ERET:   w_next_pc = w_eff_epc;
            SRC_STALL:  w_next_pc = r_pc;
            SRC_JUMP:   w_next_pc = w_jump_pc;
            SRC_BRANCH: w_next_pc = w_br_pc;
            SRC_JR:     w_next_pc = bus.jr_target;
            SRC_SEQ:    w_next_pc = w_seq_pc;
            default:    w_next_pc = w_seq_pc;
        endcase
    end

    // ---------------- state ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC_W;
            r_epc <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (bus.exc) begin
                r_epc <= bus.exc_epc;
            end else if (bus.epc_we) begin
                r_epc <= bus.epc_wdata;
            end
        end
    end

    // ---------------- fetch fault ----------------
    assign w_pc_ext        = {{(33-WIDTH){1'b0}}, r_pc};
    assign w_misaligned    = |r_pc[1:0];
    assign w_out_of_window = (w_pc_ext < FETCH_BASE) || (w_pc_ext >= FETCH_LIMIT);

    // ---------------- outputs ----------------
    assign bus.pc       = r_pc;
    assign bus.next_pc  = w_next_pc;
    assign bus.pc_plus8 = r_pc + EIGHT;
    assign bus.f_adel   = w_misaligned || w_out_of_window;
    assign bus.epc      = r_epc;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program-counter generator for the pipelined MIPS core. It holds the architectural fetch PC register and selects the next PC from sequential, jump, branch, jr, exception-entry and eret sources under a fixed priority. It also owns the EPC register and flags fetch-address faults. It sits in the F stage and consumes redirect requests resolved in D, replacing the single-cycle combinational next-PC logic.

## Interface
Parameters:
- `WIDTH`, 32: address width; legal range 28..32.
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `EXC_PC`, 32'h0000_4180: exception handler entry address.
- `IMEM_BASE`, 32'h0000_3000: lowest legal fetch address.
- `IMEM_BYTES`, 32'h0000_4000: size of the legal fetch window in bytes.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `stall` input 1: hold the PC (hazard stall from D).
- `d_pc` input WIDTH: PC of the instruction in D (the redirecting instruction).
- `j_en` input 1: j/jal in D.
- `j_instr26` input 26: instr_index field.
- `br_taken` input 1: a taken branch in D.
- `br_imm` input 16: raw branch immediate.
- `jr_en` input 1: jr/jalr in D.
- `jr_target` input WIDTH: forwarded register value.
- `exc` input 1: exception/interrupt commit request from the CP0 stage.
- `exc_epc` input WIDTH: EPC value to record on `exc`.
- `eret` input 1: eret commit.
- `epc_we` input 1: mtc0 write to EPC.
- `epc_wdata` input WIDTH: mtc0 data.
- `pc` output WIDTH: registered fetch PC.
- `next_pc` output WIDTH: combinational value `pc` takes at the next edge.
- `pc_plus8` output WIDTH: `pc + 8`, the link value for jal/jalr.
- `f_adel` output 1: the current `pc` is misaligned or outside the fetch window.
- `epc` output WIDTH: registered EPC.

## Operation
- `next_pc` is chosen by the first matching case in this priority order:
  1. `exc` → `EXC_PC`.
  2. `eret` → effective EPC. The effective EPC is `epc_wdata` when `epc_we` is high in the same cycle, otherwise `epc`.
  3. `stall` → `pc`. A stall holds the PC, but loses to `exc` and `eret`.
  4. `j_en` → `{d_pc[WIDTH-1:28], j_instr26, 2'b00}`.
  5. `br_taken` → `d_pc + 4 + (sext(br_imm) << 2)`.
  6. `jr_en` → `jr_target`, passed through unmodified.
  7. Otherwise → `pc + 4`.
- Arithmetic is modulo 2^WIDTH. Sign extension goes to WIDTH bits.
- Wrap-around is silent (0xFFFF_FFFC + 4 = 0). It is then reported by `f_adel`.
- Redirect inputs are treated as mutually exclusive by the core. If several are high, the priority above is applied and no error is raised.
- `f_adel` = `pc[1:0] != 0` OR `pc < IMEM_BASE` OR `pc >= IMEM_BASE + IMEM_BYTES`. It is purely a function of the registered `pc`.
- A `jr_target` with nonzero low bits is loaded as-is. The fault appears through `f_adel` on the following cycle.
- EPC update: `exc` loads `exc_epc`; otherwise `epc_we` loads `epc_wdata`; otherwise EPC holds.
- `exc` and `epc_we` in the same cycle: `exc` wins.
- `exc` and `eret` in the same cycle: the PC goes to `EXC_PC` and EPC loads `exc_epc`.

## Timing
- Reset values: `pc` = `RESET_PC`, `epc` = 0, `f_adel` reflects `RESET_PC` (0 with the default parameters).
- `next_pc`, `pc_plus8` and `f_adel` are combinational on the reset values while `reset` is high.
- Reset overrides every other input, including mid-stall and simultaneous `exc`.
- Latency: a redirect presented in cycle N appears on `pc` in cycle N+1. The delay-slot instruction at `d_pc + 4` has already been fetched.
- Stall: `pc` and `epc` are unchanged across every stalled edge (unless `exc` or `epc_we` is asserted). `next_pc` equals `pc` during a plain stall.
- No handshake; every input is sampled only at the rising edge.

## Test plan
- Reset then 3 free cycles → `pc` = 0x3000, 0x3004, 0x3008; `pc_plus8` = 0x3010 at 0x3008.
- `d_pc` = 0x3010, `br_taken`, `br_imm` = 0xFFFC → next `pc` = 0x3004. Same case with `br_imm` = 0x0003 → `pc` = 0x3020.
- `d_pc` = 0x3010, `j_en`, `j_instr26` = 0x0000C40 → `pc` = 0x3100. Then `stall` for 2 cycles → `pc` stays 0x3100. Then `stall` + `exc` with `exc_epc` = 0x3100 → `pc` = 0x4180, `epc` = 0x3100.
- `epc_we` with `epc_wdata` = 0x3200 and `eret` in the same cycle → `pc` = 0x3200 next cycle, `epc` = 0x3200.
- `jr_en`, `jr_target` = 0x3002 → `pc` = 0x3002 and `f_adel` = 1. Then `jr_target` = 0x7000 → `f_adel` = 1. Then `jr_target` = 0x6FFC → `f_adel` = 0.
- Assert `reset` during `stall` with `pc` = 0x4180 → `pc` = 0x3000 and `epc` = 0 on the next edge.
